// File: rtl/grf_mp_pkg.sv
// Shared constants for the general register file: hard-wired zero register and default widths.
package grf_mp_pkg;
  localparam logic [4:0] ZERO_REG = 5'd0;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;
  localparam int PW_DEF = 2;
endpackage

// File: rtl/grf_pend_ctr.sv
// Per-register pending-write counter: +inc, -dec (0..2) in one cycle, clamps at 0 and flags underflow.
module grf_pend_ctr #(
  parameter int PW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic [1:0]    dec_i,
  output logic [PW-1:0] cnt_o,
  output logic          unf_o
);
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW:0]   sum;

  // Issue gating upstream guarantees cnt+inc never exceeds 2**PW-1 after dec.
  always_comb begin
    sum   = {1'b0, cnt_q} + (PW+1)'(inc_i);
    unf_o = (PW+1)'(dec_i) > sum;
    cnt_d = unf_o ? '0 : PW'(sum - (PW+1)'(dec_i));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/grf_mp.sv
// General register file: NR bypassed read ports, two write ports (W0 wins), pending-write scoreboard.
// Optional GRF_TRACE_EN prints one trace line per retired write.
module grf_mp
  import grf_mp_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int NR = 2,
  parameter int PW = PW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NR*AW-1:0] rd_addr,
  output logic [NR*DW-1:0] rd_data,
  output logic [NR-1:0]   rd_busy,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_addr,
  output logic            iss_ready,
  input  logic            w0_we,
  input  logic [AW-1:0]   w0_addr,
  input  logic [DW-1:0]   w0_data,
  input  logic [31:0]     w0_pc,
  input  logic            w1_we,
  input  logic [AW-1:0]   w1_addr,
  input  logic [DW-1:0]   w1_data,
  input  logic [31:0]     w1_pc,
  output logic            sb_err
);
  localparam int             DEPTH = 2**AW;
  localparam logic [PW-1:0]  CMAX  = '1;
  localparam logic [AW-1:0]  ZR    = AW'(ZERO_REG);

  logic [DEPTH-1:0][DW-1:0] regs_q;
  logic [DEPTH-1:0][PW-1:0] cnt;
  logic [DEPTH-1:0][1:0]    dec;
  logic [DEPTH-1:1]         unf;
  logic                     w0_en, w1_en, sb_err_q;

  // Effective writes: reset and the zero register suppress both storage and bypass.
  assign w0_en = w0_we & rst_n & (w0_addr != ZR);
  assign w1_en = w1_we & rst_n & (w1_addr != ZR);

  assign iss_ready = (iss_addr == ZR) || (cnt[iss_addr] != CMAX) || (dec[iss_addr] != 2'd0);

  for (genvar r = 0; r < DEPTH; r++) begin : g_reg
    assign dec[r] = 2'(w0_en && (w0_addr == AW'(r))) + 2'(w1_en && (w1_addr == AW'(r)));
    if (r == 0) begin : g_zero
      assign cnt[r] = '0;
    end else begin : g_ctr
      logic inc;
      assign inc = iss_valid & iss_ready & (iss_addr == AW'(r));
      grf_pend_ctr #(.PW(PW)) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (inc),
        .dec_i (dec[r]),
        .cnt_o (cnt[r]),
        .unf_o (unf[r])
      );
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[i*AW +: AW];
    assign rd_data[i*DW +: DW] = (a == ZR)                  ? '0      :
                                 (w0_en && (w0_addr == a))  ? w0_data :
                                 (w1_en && (w1_addr == a))  ? w1_data : regs_q[a];
    assign rd_busy[i] = (PW+2)'(cnt[a]) > (PW+2)'(dec[a]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      if (w1_en) regs_q[w1_addr] <= w1_data;
      if (w0_en) regs_q[w0_addr] <= w0_data;  // same-address collision: W0 lands last
      if (|unf)  sb_err_q <= 1'b1;
    end
  end

  assign sb_err = sb_err_q;

`ifdef GRF_TRACE_EN
  always @(posedge clk) begin
    if (w0_en) $display("@%h: $%d <= %h", w0_pc, w0_addr, w0_data);
    if (w1_en && !(w0_en && (w0_addr == w1_addr))) $display("@%h: $%d <= %h", w1_pc, w1_addr, w1_data);
  end
`else
  logic unused_pc;
  assign unused_pc = ^{w0_pc, w1_pc};
`endif
endmodule

// File: tb/tb_grf_mp.sv
// Scoreboard bench for grf_mp: driver predicts outputs from an array/integer model, monitor compares at negedge.
module tb_grf_mp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ra0, ra1;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_addr;
  logic        w0_we, w1_we;
  logic [4:0]  w0_addr, w1_addr;
  logic [31:0] w0_data, w1_data, w0_pc, w1_pc;
  logic        sb_err;

  assign rd_addr = {ra1, ra0};
  always #5 clk = ~clk;

  grf_mp dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .w0_we(w0_we), .w0_addr(w0_addr), .w0_data(w0_data), .w0_pc(w0_pc),
    .w1_we(w1_we), .w1_addr(w1_addr), .w1_data(w1_data), .w1_pc(w1_pc),
    .sb_err(sb_err)
  );

  typedef struct {
    logic [31:0] d0, d1;
    logic [1:0]  busy;
    logic        rdy;
    logic        err;
    string       tag;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem[32];
  int          pend[32];
  bit          err_m;
  int          checks = 0, errors = 0;
  string       tag = "init";

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, " rd_data0"}, rd_data[31:0],  e.d0);
      chk({e.tag, " rd_data1"}, rd_data[63:32], e.d1);
      chk({e.tag, " rd_busy"},  32'(rd_busy),   32'(e.busy));
      chk({e.tag, " iss_ready"}, 32'(iss_ready), 32'(e.rdy));
      chk({e.tag, " sb_err"},   32'(sb_err),    32'(e.err));
    end
  end

  function automatic logic [31:0] rd_model(int a);
    if (a == 0) return 0;
    if (w0_we && int'(w0_addr) == a) return w0_data;
    if (w1_we && int'(w1_addr) == a) return w1_data;
    return mem[a];
  endfunction

  // Predict this cycle's outputs from the model, advance the model, then let the edge happen.
  task automatic tick();
    int d[32];
    exp_t e;
    int ra[2];
    ra[0] = int'(ra0);
    ra[1] = int'(ra1);
    for (int r = 0; r < 32; r++)
      d[r] = ((r != 0 && w0_we && int'(w0_addr) == r) ? 1 : 0) +
             ((r != 0 && w1_we && int'(w1_addr) == r) ? 1 : 0);
    if (rst_n) begin
      e.d0 = rd_model(ra[0]);
      e.d1 = rd_model(ra[1]);
      for (int p = 0; p < 2; p++) e.busy[p] = (ra[p] != 0) && (pend[ra[p]] - d[ra[p]] > 0);
      e.rdy = (iss_addr == 0) || (pend[iss_addr] < 3) || (d[iss_addr] > 0);
      e.err = err_m;
      e.tag = tag;
      q.push_back(e);
      if (w1_we && w1_addr != 0) mem[w1_addr] = w1_data;
      if (w0_we && w0_addr != 0) mem[w0_addr] = w0_data;
      for (int r = 1; r < 32; r++) begin
        int n;
        n = pend[r] + ((iss_valid && e.rdy && int'(iss_addr) == r) ? 1 : 0) - d[r];
        if (n < 0) begin n = 0; err_m = 1; end
        pend[r] = n;
      end
    end else begin
      for (int r = 0; r < 32; r++) begin mem[r] = 0; pend[r] = 0; end
      err_m = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 0; iss_addr = 0;
    w0_we = 0; w0_addr = 0; w0_data = 0;
    w1_we = 0; w1_addr = 0; w1_data = 0;
  endtask

  initial begin
    rst_n = 0; ra0 = 0; ra1 = 0; w0_pc = 32'h100; w1_pc = 32'h104;
    idle();
    for (int r = 0; r < 32; r++) begin mem[r] = 0; pend[r] = 0; end
    err_m = 0;
    @(posedge clk); #1;

    // 1: reset overrides a concurrent write to $3
    tag = "reset"; w0_we = 1; w0_addr = 3; w0_data = 32'hDEAD; tick();
    rst_n = 1; idle(); ra0 = 3; ra1 = 0; tick();

    // 2: write bypass then stored value
    tag = "bypass"; ra0 = 5; w0_we = 1; w0_addr = 5; w0_data = 32'h1234; tick();
    idle(); tick();

    // 3: dual write same address, W0 wins
    tag = "collide"; ra0 = 7; ra1 = 7;
    w0_we = 1; w0_addr = 7; w0_data = 32'hAAAA; w1_we = 1; w1_addr = 7; w1_data = 32'h5555; tick();
    idle(); tick();

    // 4: saturate $9, then retire-and-issue in one cycle
    tag = "sat"; ra0 = 9; ra1 = 9;
    iss_valid = 1; iss_addr = 9;
    repeat (4) tick();
    w1_we = 1; w1_addr = 9; w1_data = 32'h99; tick();
    idle(); tick();

    // 5: busy clears when the pending write arrives
    tag = "busy"; ra1 = 4; ra0 = 0; iss_valid = 1; iss_addr = 4; tick();
    idle(); tick();
    w0_we = 1; w0_addr = 4; w0_data = 32'h4444; tick();
    idle(); tick();

    // 6: underflow is sticky; writes to $0 are ignored
    tag = "unf"; ra0 = 6; w0_we = 1; w0_addr = 6; w0_data = 32'h66; tick();
    idle(); ra0 = 0; ra1 = 0; w0_we = 1; w0_addr = 0; w0_data = 32'hFFFF;
    w1_we = 1; w1_addr = 0; w1_data = 32'hEEEE; tick();
    idle(); repeat (2) tick();
    rst_n = 0; tick();
    rst_n = 1; tick();

    // Random traffic on a small register window to provoke collisions and saturation
    tag = "rand";
    for (int n = 0; n < 600; n++) begin
      rst_n     = ($urandom_range(0, 79) != 0);
      ra0       = 5'($urandom_range(0, 7));
      ra1       = 5'($urandom_range(0, 7));
      iss_valid = $urandom_range(0, 1) == 1;
      iss_addr  = 5'($urandom_range(0, 7));
      w0_we     = $urandom_range(0, 2) == 0;
      w0_addr   = 5'($urandom_range(0, 7));
      w0_data   = $urandom;
      w1_we     = $urandom_range(0, 2) == 0;
      w1_addr   = 5'($urandom_range(0, 7));
      w1_data   = $urandom;
      w0_pc     = $urandom;
      w1_pc     = $urandom;
      tick();
    end
    idle(); rst_n = 1; tick();

    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
